// File: rtl/sr_cmd_debouncer_if.sv
// Button/command bundle between the raw push-buttons and the SR command stage.
//   set_btn, rst_btn : raw asynchronous buttons (driven by master)
//   S, R             : one-cycle set/reset pulses to the SR flip-flop (driven by slave)
//   set_level        : debounced level of set_btn
//   rst_level        : debounced level of rst_btn
//   conflict         : one-cycle flag, both pulses were due and the loser was dropped
interface sr_cmd_debouncer_if;
   logic set_btn;
   logic rst_btn;
   logic S;
   logic R;
   logic set_level;
   logic rst_level;
   logic conflict;

   modport master (output set_btn, rst_btn,
                   input  S, R, set_level, rst_level, conflict);
   modport slave  (input  set_btn, rst_btn,
                   output S, R, set_level, rst_level, conflict);
endinterface

// File: rtl/sr_cmd_debouncer.sv
// Command front-end for an SR flip-flop: two raw buttons are synchronised,
// debounced and rising-edge detected, producing one S or R pulse per press.
// S and R are never high together; PRIORITY_SET picks the winner and the
// loser is dropped (flagged on conflict).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sr_cmd_debouncer_if.slave (buttons in, pulses/levels/conflict out)
// Optional feature macro: SRCMD_AUTOREPEAT_EN -- while a button stays
// accepted-high, its pulse is re-issued every REPEAT_CYCLES clocks.
module sr_cmd_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8,
   parameter int CNT_W           = 16,
   parameter int PRIORITY_SET    = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   sr_cmd_debouncer_if.slave   bus
);

   typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DB_CNT  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic             PRIO_S  = (PRIORITY_SET != 0);

   // bit 0 = set channel, bit 1 = reset channel
   logic [1:0] btn;
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] level;
   logic [1:0] due;
   logic       s_q, r_q, conflict_q;

   assign btn = {bus.rst_btn, bus.set_btn};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      db_state_e        state_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_inc;
      logic             lvl_q, lvl_dly_q;
      logic             s2;
      logic             rise;

      assign s2      = sync2_q[ch];
      assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      // Debounce FSM: any sample disagreeing with the pending direction
      // falls back to the old stable state with the count cleared.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
         end else begin
            case (state_q)
               STABLE_LO: if (s2) begin
                  if (DEBOUNCE_CYCLES <= 1) begin
                     state_q <= STABLE_HI;
                     lvl_q   <= 1'b1;
                  end else begin
                     state_q <= WAIT_HI;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               WAIT_HI: if (!s2) begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
               end else if (cnt_inc >= DB_CNT) begin
                  state_q <= STABLE_HI;
                  lvl_q   <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_inc;
               end
               STABLE_HI: if (!s2) begin
                  if (DEBOUNCE_CYCLES <= 1) begin
                     state_q <= STABLE_LO;
                     lvl_q   <= 1'b0;
                  end else begin
                     state_q <= WAIT_LO;
                     cnt_q   <= CNT_W'(1);
                  end
               end
               WAIT_LO: if (s2) begin
                  state_q <= STABLE_HI;
                  cnt_q   <= '0;
               end else if (cnt_inc >= DB_CNT) begin
                  state_q <= STABLE_LO;
                  lvl_q   <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_inc;
               end
               default: begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
                  lvl_q   <= 1'b0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) lvl_dly_q <= 1'b0;
         else        lvl_dly_q <= lvl_q;
      end

      // High for the one cycle right after the debounced level rises.
      assign rise = lvl_q & ~lvl_dly_q;

`ifdef SRCMD_AUTOREPEAT_EN
      localparam logic [CNT_W-1:0] RP_CNT = CNT_W'(REPEAT_CYCLES);
      logic [CNT_W-1:0] rep_q;
      logic             hit;

      // rep_q restarts at 1 on every issued pulse, so the next one lands
      // exactly REPEAT_CYCLES clocks later.
      assign hit = (state_q == STABLE_HI) && (rep_q >= RP_CNT);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                      rep_q <= '0;
         else if (state_q != STABLE_HI)   rep_q <= '0;
         else if (rise || hit)            rep_q <= CNT_W'(1);
         else if (rep_q != CNT_MAX)       rep_q <= rep_q + 1'b1;
      end

      assign due[ch] = rise | hit;
`else
      assign due[ch] = rise;
`endif

      assign level[ch] = lvl_q;
   end

`ifndef SRCMD_AUTOREPEAT_EN
   logic [31:0] unused_repeat;
   assign unused_repeat = REPEAT_CYCLES;
`endif

   // Priority resolution; the losing pulse is discarded, not deferred.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         s_q        <= due[0] & (~due[1] |  PRIO_S);
         r_q        <= due[1] & (~due[0] | ~PRIO_S);
         conflict_q <= due[0] & due[1];
      end
   end

   assign bus.S         = s_q;
   assign bus.R         = r_q;
   assign bus.set_level = level[0];
   assign bus.rst_level = level[1];
   assign bus.conflict  = conflict_q;

endmodule
